// File: rtl/uart_tx.sv
// Configuration readback transmitter: on start, snapshots PAR_NUM bytes and sends them
// highest index first as UART frames (start, 8 data LSB first, stop bits, optional gap).
module uart_tx #(
   parameter int unsigned CLK_PER_BIT = 52,
   parameter int unsigned PAR_NUM     = 5,
   parameter int unsigned STOP_BITS   = 1,
   parameter int unsigned GAP_BITS    = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [8*PAR_NUM-1:0] conf_in,
   output logic                 tx,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned CW          = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
   localparam int unsigned BW          = (PAR_NUM > 1) ? $clog2(PAR_NUM) : 1;
   localparam int unsigned RW          = 3;
   localparam int unsigned STOP_RELOAD = (STOP_BITS > 1) ? STOP_BITS - 1 : 0;
   localparam int unsigned GAP_RELOAD  = (GAP_BITS > 1) ? GAP_BITS - 1 : 0;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   state_t                    r_state, w_state_nxt;
   logic [CW-1:0]             r_bit_cnt, w_bit_cnt_nxt;
   logic [2:0]                r_data_bit, w_data_bit_nxt;
   logic [BW-1:0]             r_byte_idx, w_byte_idx_nxt;
   logic [RW-1:0]             r_rep, w_rep_nxt;
   logic [PAR_NUM-1:0][7:0]   r_snap;
   logic                      w_capture;
   logic                      w_tick;
   logic                      r_tx, r_busy, r_done;
   logic                      w_tx_nxt, w_busy_nxt, w_done_nxt;

   assign w_tick = (r_bit_cnt == '0);

   // State, counters, snapshot and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_bit_cnt  <= '0;
         r_data_bit <= '0;
         r_byte_idx <= '0;
         r_rep      <= '0;
         r_snap     <= '0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_data_bit <= w_data_bit_nxt;
         r_byte_idx <= w_byte_idx_nxt;
         r_rep      <= w_rep_nxt;
         if (w_capture) r_snap <= conf_in;
         r_tx       <= w_tx_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
      end
   end

   // Next state; r_rep counts remaining whole bit times in STOP and GAP
   always_comb begin
      w_state_nxt    = r_state;
      w_bit_cnt_nxt  = w_tick ? CW'(CLK_PER_BIT - 1) : r_bit_cnt - CW'(1);
      w_data_bit_nxt = r_data_bit;
      w_byte_idx_nxt = r_byte_idx;
      w_rep_nxt      = r_rep;
      w_capture      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_bit_cnt_nxt = r_bit_cnt;
            if (start) begin
               w_state_nxt    = S_START;
               w_byte_idx_nxt = BW'(PAR_NUM - 1);
               w_bit_cnt_nxt  = CW'(CLK_PER_BIT - 1);
               w_capture      = 1'b1;
            end
         end
         S_START: begin
            if (w_tick) begin
               w_state_nxt    = S_DATA;
               w_data_bit_nxt = 3'd0;
            end
         end
         S_DATA: begin
            if (w_tick) begin
               if (r_data_bit == 3'd7) begin
                  w_state_nxt = S_STOP;
                  w_rep_nxt   = RW'(STOP_RELOAD);
               end else begin
                  w_data_bit_nxt = r_data_bit + 3'd1;
               end
            end
         end
         S_STOP: begin
            if (w_tick) begin
               if (r_rep != '0) begin
                  w_rep_nxt = r_rep - RW'(1);
               end else if (r_byte_idx != '0) begin
                  w_byte_idx_nxt = r_byte_idx - BW'(1);
                  if (GAP_BITS == 0) begin
                     w_state_nxt = S_START;
                  end else begin
                     w_state_nxt = S_GAP;
                     w_rep_nxt   = RW'(GAP_RELOAD);
                  end
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_GAP: begin
            if (w_tick) begin
               if (r_rep != '0) w_rep_nxt = r_rep - RW'(1);
               else             w_state_nxt = S_START;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs decoded from the upcoming state so they change on the same edge as the FSM
   always_comb begin
      w_tx_nxt   = 1'b1;
      w_busy_nxt = (w_state_nxt != S_IDLE);
      w_done_nxt = (r_state == S_STOP) && (w_state_nxt == S_IDLE);
      case (w_state_nxt)
         S_START: w_tx_nxt = 1'b0;
         S_DATA:  w_tx_nxt = r_snap[w_byte_idx_nxt][w_data_bit_nxt];
         default: w_tx_nxt = 1'b1;
      endcase
   end

   assign tx   = r_tx;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a default instance and a 2-stop/1-gap instance, checked cycle by
// cycle against an arithmetic line model plus a mid-bit decoder acting as the receiver.
module tb_uart_tx;

   localparam int CPB = 52;
   localparam int NP  = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_a, start_b;
   logic [39:0]   conf_a, conf_b;
   logic          tx_a, busy_a, done_a;
   logic          tx_b, busy_b, done_b;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   uart_tx u_a (
      .clk     (clk),
      .rst     (rst),
      .start   (start_a),
      .conf_in (conf_a),
      .tx      (tx_a),
      .busy    (busy_a),
      .done    (done_a)
   );

   uart_tx #(.STOP_BITS(2), .GAP_BITS(1)) u_b (
      .clk     (clk),
      .rst     (rst),
      .start   (start_b),
      .conf_in (conf_b),
      .tx      (tx_b),
      .busy    (busy_b),
      .done    (done_b)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected line level t cycles after the first start bit begins
   function automatic logic model_tx(input logic [39:0] b, input int t, input int sb, input int gb);
      int         frame;
      int         period;
      int         f;
      int         pos;
      logic [7:0] byt;
      frame  = (9 + sb) * CPB;
      period = frame + gb * CPB;
      f      = t / period;
      pos    = (t % period) / CPB;
      if (f >= NP) return 1'b1;
      byt = b[8*(NP-1-f) +: 8];
      if (pos == 0) return 1'b0;
      if (pos <= 8) return byt[pos-1];
      return 1'b1;
   endfunction

   // One burst: start drive, per-cycle line compare, receiver decode, done/busy timing
   task automatic burst(input logic [39:0] bytes, input int sb, input int gb,
                        input bit sel, input bit poke, input bit hold);
      int         len;
      int         period;
      int         tx_err;
      int         busy_err;
      int         early_done;
      logic [7:0] dec [NP];
      logic       o_tx, o_busy, o_done;
      period     = (9 + sb) * CPB + gb * CPB;
      len        = NP * (9 + sb) * CPB + (NP - 1) * gb * CPB;
      tx_err     = 0;
      busy_err   = 0;
      early_done = 0;
      for (int i = 0; i < NP; i++) dec[i] = 8'h00;
      if (sel) begin start_b = 1'b1; conf_b = bytes; end
      else     begin start_a = 1'b1; conf_a = bytes; end
      @(negedge clk);
      if (!hold) begin
         if (sel) start_b = 1'b0;
         else     start_a = 1'b0;
      end
      o_tx   = sel ? tx_b : tx_a;
      o_busy = sel ? busy_b : busy_a;
      chk("first_low_latency", 64'(o_tx), 64'(0));
      chk("busy_rise_latency", 64'(o_busy), 64'(1));
      for (int t = 0; t < len; t++) begin
         int r;
         int pos;
         if (t > 0) @(negedge clk);
         o_tx   = sel ? tx_b : tx_a;
         o_busy = sel ? busy_b : busy_a;
         o_done = sel ? done_b : done_a;
         if (o_tx !== model_tx(bytes, t, sb, gb)) tx_err++;
         if (o_busy !== 1'b1) busy_err++;
         if (o_done !== 1'b0) early_done++;
         r   = t % period;
         pos = r / CPB;
         if ((r % CPB) == CPB / 2 && pos >= 1 && pos <= 8) dec[t / period][pos-1] = o_tx;
         if (poke) begin
            if (t == 10) conf_a = {NP{8'h55}};
            if (t == 100 || t == 1500) start_a = 1'b1;
            if (t == 101 || t == 1501) start_a = 1'b0;
         end
      end
      @(negedge clk);
      o_tx   = sel ? tx_b : tx_a;
      o_busy = sel ? busy_b : busy_a;
      o_done = sel ? done_b : done_a;
      chk("done_at_burst_end", 64'(o_done), 64'(1));
      chk("busy_fall_at_end", 64'(o_busy), 64'(0));
      chk("tx_idle_at_end", 64'(o_tx), 64'(1));
      for (int f = 0; f < NP; f++) chk("decoded_byte", 64'(dec[f]), 64'(bytes[8*(NP-1-f) +: 8]));
      chk("line_mismatch_cycles", 64'(tx_err), 64'(0));
      chk("busy_drop_cycles", 64'(busy_err), 64'(0));
      chk("early_done_cycles", 64'(early_done), 64'(0));
      if (!hold) begin
         @(negedge clk);
         o_tx   = sel ? tx_b : tx_a;
         o_busy = sel ? busy_b : busy_a;
         o_done = sel ? done_b : done_a;
         chk("done_single_cycle", 64'(o_done), 64'(0));
         chk("idle_after_burst", 64'({o_busy, o_tx}), 64'(2'b01));
      end
   endtask

   initial begin
      logic [39:0] rb;
      int          bad;
      rst     = 1'b1;
      start_a = 1'b0;
      start_b = 1'b0;
      conf_a  = '0;
      conf_b  = '0;
      repeat (3) @(negedge clk);
      chk("reset_tx", 64'(tx_a), 64'(1));
      chk("reset_busy", 64'(busy_a), 64'(0));
      chk("reset_done", 64'(done_a), 64'(0));
      chk("reset_tx_b", 64'(tx_b), 64'(1));
      rst = 1'b0;
      @(negedge clk);

      burst(40'hA5_3C_00_FF_81, 1, 0, 1'b0, 1'b0, 1'b0);
      burst(40'h12_34_56_78_9A, 1, 0, 1'b0, 1'b1, 1'b0);
      repeat (2) begin
         rb = {8'($urandom), 32'($urandom)};
         burst(rb, 1, 0, 1'b0, 1'b0, 1'b0);
      end

      // Continuous start on the 2-stop/1-gap instance: bursts chained with one idle cycle
      rb = {8'($urandom), 32'($urandom)};
      burst(rb, 2, 1, 1'b1, 1'b0, 1'b1);
      rb = {8'($urandom), 32'($urandom)};
      burst(rb, 2, 1, 1'b1, 1'b0, 1'b1);
      rb = {8'($urandom), 32'($urandom)};
      burst(rb, 2, 1, 1'b1, 1'b0, 1'b0);

      // Reset in the middle of byte 2's data bits (an all-zero byte so tx is low)
      rb      = 40'hFF_FF_00_FF_FF;
      conf_a  = rb;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (2 * 10 * CPB + 4 * CPB + 10) @(negedge clk);
      chk("pre_reset_tx", 64'(tx_a), 64'(model_tx(rb, 2 * 10 * CPB + 4 * CPB + 10, 1, 0)));
      rst = 1'b1;
      #1;
      chk("async_reset_tx", 64'(tx_a), 64'(1));
      chk("async_reset_busy", 64'(busy_a), 64'(0));
      chk("async_reset_done", 64'(done_a), 64'(0));
      repeat (3) @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (600) begin
         @(negedge clk);
         if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) bad++;
      end
      chk("quiet_after_reset", 64'(bad), 64'(0));

      rb = {8'($urandom), 32'($urandom)};
      burst(rb, 1, 0, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
